// File: rtl/riscv_pkg.sv
// riscv_pkg: shared MemOp encodings, dmem FSM state codes and access-size helpers.
// Revision 1.0
`default_nettype none

package riscv_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  // Signedness lives in op[2]; the size is fully encoded by op[1:0].
  function automatic logic is_half(input logic [2:0] op);
    return (op[1:0] == MEMOP_H[1:0]);
  endfunction

  function automatic logic is_word(input logic [2:0] op);
    return (op[1:0] == MEMOP_W[1:0]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_align_check.sv
// mem_align_check: flags half/word accesses whose address is not naturally aligned.
// Revision 1.0
`default_nettype none

module mem_align_check
  import riscv_pkg::*;
(
  input  logic [2:0] i_mem_op,
  input  logic [1:0] i_addr_lo,
  output logic       o_misaligned
);

  assign o_misaligned = (is_half(i_mem_op) & i_addr_lo[0]) |
                        (is_word(i_mem_op) & (|i_addr_lo));

endmodule

`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage sequencer for a variable-latency data memory with
// alignment check, access timeout and registered load data. Revision 1.0
`default_nettype none

module dmem_access_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic            flush_in,
  input  logic            MemRead_in,
  input  logic            MemWrite_in,
  input  logic [2:0]      MemOp_in,
  input  logic [XLEN-1:0] addr_in,
  input  logic [XLEN-1:0] wdata_in,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [2:0]      dmem_op,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall_out,
  output logic [XLEN-1:0] rdata_out,
  output logic            rdata_valid,
  output logic            misalign_exc,
  output logic            bus_err
);

  localparam int            CW         = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] c_cnt_last = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_we;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_rdata;

  logic w_acc;
  logic w_misaligned;
  logic w_idle;
  logic w_issue;
  logic w_timeout;

  mem_align_check u_align (
    .i_mem_op     (MemOp_in),
    .i_addr_lo    (addr_in[1:0]),
    .o_misaligned (w_misaligned)
  );

  assign w_acc     = ex_valid & ~flush_in & (MemRead_in | MemWrite_in);
  assign w_idle    = (r_state == S_IDLE);
  assign w_issue   = w_idle & w_acc & ~w_misaligned;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == c_cnt_last);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_op    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_issue) begin
            // A simultaneous read+write request is serviced as a read.
            r_we    <= MemWrite_in & ~MemRead_in;
            r_op    <= MemOp_in;
            r_addr  <= addr_in;
            r_wdata <= wdata_in;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (dmem_ack) begin
            r_rdata <= r_we ? '0 : dmem_rdata;
            r_cnt   <= '0;
            r_state <= S_RESP;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_cnt   <= '0;
            r_state <= S_ERR;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dmem_req     = (r_state == S_BUSY);
  assign dmem_we      = r_we;
  assign dmem_op      = r_op;
  assign dmem_addr    = r_addr;
  assign dmem_wdata   = r_wdata;
  assign stall_out    = w_issue | (r_state == S_BUSY);
  assign misalign_exc = w_idle & w_acc & w_misaligned;
  assign rdata_valid  = (r_state == S_RESP) & ~r_we;
  assign bus_err      = (r_state == S_ERR);
  assign rdata_out    = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: scoreboard bench with a behavioural memory and instruction model.
// Revision 1.0
`default_nettype none

module tb_dmem_access_ctrl;

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          kind;  // 0 load data, 1 bus error, 2 misalign
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    int          d;     // BUSY cycles before ack; >= 16 means never
    logic [31:0] rdata;
  } mem_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid = 1'b0, flush_in = 1'b0, MemRead_in = 1'b0, MemWrite_in = 1'b0;
  logic [2:0]  MemOp_in = '0;
  logic [31:0] addr_in = '0, wdata_in = '0;
  logic        dmem_req, dmem_we;
  logic [2:0]  dmem_op;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        stall_out, rdata_valid, misalign_exc, bus_err;
  logic [31:0] rdata_out;

  dmem_access_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .flush_in(flush_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .MemOp_in(MemOp_in),
    .addr_in(addr_in), .wdata_in(wdata_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_op(dmem_op), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_out(stall_out),
    .rdata_out(rdata_out), .rdata_valid(rdata_valid), .misalign_exc(misalign_exc),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  int   exp_stall[$];
  mem_t mem_q[$];
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural memory: ack after a chosen number of BUSY cycles, noise when idle.
  bit   mem_in = 1'b0;
  int   mem_n = 0;
  mem_t mem_cur;
  always @(negedge clk) begin
    if (dmem_req) begin
      if (!mem_in) begin
        mem_in = 1'b1;
        mem_n  = 0;
        if (mem_q.size() > 0) mem_cur = mem_q.pop_front();
        else begin mem_cur.d = 99; mem_cur.rdata = '0; end
      end
      dmem_ack   = (mem_n == mem_cur.d);
      dmem_rdata = dmem_ack ? mem_cur.rdata : $urandom;
      mem_n++;
    end else begin
      mem_in     = 1'b0;
      dmem_ack   = ($urandom_range(0, 3) == 0);
      dmem_rdata = $urandom;
    end
  end

  // Request monitor: checks issued transactions and their stability while BUSY.
  bit   mon_in = 1'b0;
  req_t mon_cur;
  always @(negedge clk) begin
    if (dmem_req) begin
      if (!mon_in) begin
        mon_in = 1'b1;
        if (exp_req.size() == 0) begin
          chk("req_unexpected", 32'd1, 32'd0);
          mon_cur.we = dmem_we; mon_cur.op = dmem_op;
          mon_cur.addr = dmem_addr; mon_cur.wdata = dmem_wdata;
        end else begin
          mon_cur = exp_req.pop_front();
          chk("req_we_op", {28'd0, dmem_we, dmem_op}, {28'd0, mon_cur.we, mon_cur.op});
          chk("req_addr", dmem_addr, mon_cur.addr);
          chk("req_wdata", dmem_wdata, mon_cur.wdata);
        end
      end else begin
        chk("req_stable_addr", dmem_addr, mon_cur.addr);
      end
    end else begin
      mon_in = 1'b0;
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    rsp_t       r;
    logic [2:0] act_k, exp_k;
    if (rdata_valid | bus_err | misalign_exc) begin
      act_k = {rdata_valid, bus_err, misalign_exc};
      if (exp_rsp.size() == 0) begin
        chk("rsp_unexpected", {29'd0, act_k}, 32'd0);
      end else begin
        r = exp_rsp.pop_front();
        exp_k = (r.kind == 0) ? 3'b100 : (r.kind == 1) ? 3'b010 : 3'b001;
        chk("rsp_kind", {29'd0, act_k}, {29'd0, exp_k});
        if (r.kind == 0) chk("rdata_out", rdata_out, r.data);
        if (r.kind == 1) chk("err_rdata_zero", rdata_out, 32'd0);
        if (r.kind == 2) chk("misalign_no_stall", {30'd0, stall_out, dmem_req}, 32'd0);
      end
    end
  end

  // Stall monitor: length of each contiguous stall run.
  int run = 0;
  always @(negedge clk) begin
    if (stall_out) run++;
    else if (run > 0) begin
      if (exp_stall.size() == 0) chk("stall_unexpected", run, 0);
      else chk("stall_cycles", run, exp_stall.pop_front());
      run = 0;
    end
  end

  // Reference model of one instruction, then drives it and waits for it to retire.
  task automatic issue(input bit v, input bit f, input bit rd, input bit wr,
                       input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input int d, input logic [31:0] rdat);
    int   size;
    bit   acc, mis;
    req_t q;
    rsp_t s;
    mem_t m;
    int   k;
    acc  = v && !f && (rd || wr);
    size = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
    mis  = (a % size) != 0;
    if (acc && mis) begin
      s.kind = 2; s.data = '0; exp_rsp.push_back(s);
    end else if (acc) begin
      q.we = wr && !rd; q.op = op; q.addr = a; q.wdata = wd;
      exp_req.push_back(q);
      m.d = d; m.rdata = rdat; mem_q.push_back(m);
      if (d < 16) begin
        exp_stall.push_back(d + 2);
        if (!q.we) begin s.kind = 0; s.data = rdat; exp_rsp.push_back(s); end
      end else begin
        exp_stall.push_back(17);
        s.kind = 1; s.data = '0; exp_rsp.push_back(s);
      end
    end
    ex_valid = v; flush_in = f; MemRead_in = rd; MemWrite_in = wr;
    MemOp_in = op; addr_in = a; wdata_in = wd;
    k = 0;
    forever begin
      @(negedge clk);
      if (!stall_out) break;
      k++;
      if (k > 40) begin
        chk("stall_bound", 32'd1, 32'd0);
        break;
      end
      @(posedge clk); #1;
      flush_in = $urandom_range(0, 1);
    end
    @(posedge clk); #1;
    ex_valid = 1'b0; flush_in = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rd_ops [5];
    logic [2:0]  op;
    logic [31:0] a;
    bit          v, f, rd, wr;
    int          d;
    rd_ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    chk("rst_pulses", {29'd0, rdata_valid, bus_err, misalign_exc}, 32'd0);
    chk("rst_rdata", rdata_out, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_we", {31'd0, dmem_we}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    issue(1, 0, 1, 0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF);
    issue(1, 0, 0, 1, 3'b010, 32'h204, 32'h12345678, 0, 32'h0);
    issue(1, 0, 1, 0, 3'b001, 32'h101, 32'h0, 0, 32'h0);
    issue(1, 0, 1, 0, 3'b010, 32'h300, 32'h0, 99, 32'h0);
    issue(1, 0, 1, 0, 3'b010, 32'h304, 32'h0, 1, 32'hCAFEF00D);
    issue(1, 0, 1, 0, 3'b010, 32'h308, 32'h0, 15, 32'h0BADC0DE);
    issue(1, 0, 1, 0, 3'b010, 32'h40C, 32'h0, 0, 32'h11111111);
    issue(1, 0, 1, 0, 3'b010, 32'h410, 32'h0, 0, 32'h22222222);
    issue(1, 1, 1, 0, 3'b010, 32'h414, 32'h0, 0, 32'h33333333);
    issue(1, 0, 0, 0, 3'b010, 32'h418, 32'h0, 0, 32'h0);
    issue(1, 0, 1, 1, 3'b101, 32'h41E, 32'h55AA55AA, 3, 32'h0000FFFF);
    issue(1, 0, 1, 0, 3'b100, 32'h503, 32'h0, 0, 32'h000000A5);

    // Reset in the middle of a hung access: request abandoned on the next edge.
    begin
      req_t q;
      mem_t m;
      q.we = 1'b0; q.op = 3'b010; q.addr = 32'h600; q.wdata = 32'h0;
      exp_req.push_back(q);
      m.d = 99; m.rdata = '0; mem_q.push_back(m);
      exp_stall.push_back(4);
      ex_valid = 1'b1; MemRead_in = 1'b1; MemOp_in = 3'b010; addr_in = 32'h600;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0; ex_valid = 1'b0; MemRead_in = 1'b0;
      @(posedge clk); #1;
      chk("rst_busy_req", {31'd0, dmem_req}, 32'd0);
      chk("rst_busy_stall", {31'd0, stall_out}, 32'd0);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
    end

    for (int i = 0; i < 300; i++) begin
      v  = ($urandom_range(0, 7) != 0);
      f  = ($urandom_range(0, 5) == 0);
      rd = $urandom_range(0, 1);
      wr = $urandom_range(0, 1);
      if (wr && !rd) op = rd_ops[$urandom_range(0, 2)];
      else op = rd_ops[$urandom_range(0, 4)];
      a = $urandom;
      d = ($urandom_range(0, 11) == 0) ? 99 : $urandom_range(0, 6);
      issue(v, f, rd, wr, op, a, $urandom, d, $urandom);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("left_req", exp_req.size(), 0);
    chk("left_rsp", exp_rsp.size(), 0);
    chk("left_stall", exp_stall.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
